// File: rtl/neorv32_if.sv
// ---------------------------------------------------------------------------
// neorv32_if -- instruction fetch front end
//
// Issues sequential instruction-ROM reads from a PC register and hands the
// returned words to the decode stage over a valid/ready handshake. The ROM
// has one cycle of read latency. A one-entry skid buffer holds the word that
// arrives while decode is stalling. Execute can redirect fetch with jump_en_i.
// A redirect discards anything that is in flight or buffered.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active high
//   jump_en_i    redirect request (taken branch/jump)
//   jump_addr_i  redirect target (low two bits ignored)
//   rom_en_o     ROM read strobe, one read per cycle it is high
//   rom_addr_o   ROM byte address (the PC register)
//   rom_data_i   ROM read data, valid the cycle after rom_en_o
//   inst_valid_o instruction available to decode
//   inst_ready_i decode accepts the instruction this cycle
//   inst_o       instruction word (NOP_INST when not valid)
//   inst_addr_o  byte address of inst_o (zero when not valid)
// ---------------------------------------------------------------------------
module neorv32_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        rom_en_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    logic [31:0] pc;
    logic        req_vld;
    logic [31:0] req_addr;
    logic        skid_vld;
    logic [31:0] skid_inst;
    logic [31:0] skid_addr;
    logic        stall;

    assign rom_addr_o = pc;

    always_comb begin
        inst_valid_o = 1'b0;
        inst_o       = NOP_INST;
        inst_addr_o  = '0;
        if (skid_vld) begin
            inst_valid_o = 1'b1;
            inst_o       = skid_inst;
            inst_addr_o  = skid_addr;
        end else if (req_vld) begin
            inst_valid_o = 1'b1;
            inst_o       = rom_data_i;
            inst_addr_o  = req_addr;
        end
        // A redirect kills whatever is being presented this cycle.
        if (jump_en_i) begin
            inst_valid_o = 1'b0;
            inst_o       = NOP_INST;
            inst_addr_o  = '0;
        end
    end

    assign stall = inst_valid_o & ~inst_ready_i;

    // Issue is held off while stalled or while the skid holds a word, so at
    // most one word is ever outstanding and the skid cannot overflow.
    assign rom_en_o = ~rst & ~jump_en_i & ~skid_vld & ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            req_vld   <= 1'b0;
            req_addr  <= '0;
            skid_vld  <= 1'b0;
            skid_inst <= '0;
            skid_addr <= '0;
        end else if (jump_en_i) begin
            pc       <= jump_addr_i & 32'hFFFF_FFFC;
            req_vld  <= 1'b0;
            skid_vld <= 1'b0;
        end else begin
            if (rom_en_o) begin
                req_addr <= pc;
                req_vld  <= 1'b1;
                pc       <= pc + 32'd4;
            end else begin
                req_vld <= 1'b0;
            end

            if (req_vld && !skid_vld && stall) begin
                skid_inst <= rom_data_i;
                skid_addr <= req_addr;
                skid_vld  <= 1'b1;
            end else if (skid_vld && inst_ready_i) begin
                skid_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_neorv32_if.sv
// ---------------------------------------------------------------------------
// tb_neorv32_if -- self-checking bench for neorv32_if
//
// A behavioural ROM returns 32'h1000_0000 + word index one cycle after each
// read. Addresses the decode side is expected to accept are pushed into a
// queue. A negedge monitor pops the queue on every accepted handshake and
// checks the address and the data word. Cycle-specific properties are checked
// inline: stall hold, bubble, redirect kill/latency, wrap and async reset.
// ---------------------------------------------------------------------------
module tb_neorv32_if;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        rom_en_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] sb[$];

    neorv32_if #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .jump_en_i   (jump_en_i),
        .jump_addr_i (jump_addr_i),
        .rom_en_o    (rom_en_o),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data_i),
        .inst_valid_o(inst_valid_o),
        .inst_ready_i(inst_ready_i),
        .inst_o      (inst_o),
        .inst_addr_o (inst_addr_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    // Synchronous ROM, one cycle read latency.
    always @(posedge clk) begin
        if (rom_en_o) rom_data_i <= rom_word(rom_addr_o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard consumer: every accepted instruction must be the next expected one.
    always @(negedge clk) begin
        if (!rst && inst_valid_o && inst_ready_i) begin
            if (sb.size() == 0) begin
                check("sb_extra", inst_addr_o, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                check("sb_addr", inst_addr_o, e);
                check("sb_data", inst_o, rom_word(e));
            end
        end
    end

    // Entered just after a rising edge: redirects this cycle, then expects
    // n consecutive valid instructions starting two cycles later.
    task automatic jump_to(input logic [31:0] target, input int unsigned n);
        logic [31:0] a;
        a = target & 32'hFFFF_FFFC;
        for (int unsigned i = 0; i < n; i++) sb.push_back(a + 32'(4 * i));
        jump_en_i   = 1'b1;
        jump_addr_i = target;
        @(negedge clk);
        check("jmp_valid", 32'(inst_valid_o), 32'd0);
        check("jmp_rom_en", 32'(rom_en_o), 32'd0);
        @(posedge clk); #1;
        jump_en_i    = 1'b0;
        inst_ready_i = 1'b1;
        @(negedge clk);
        check("jmp_bubble", 32'(inst_valid_o), 32'd0);
        check("jmp_issue", rom_addr_o, a);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            check("jmp_stream", 32'(inst_valid_o), 32'd1);
        end
    endtask

    initial begin
        rst          = 1'b1;
        jump_en_i    = 1'b0;
        jump_addr_i  = '0;
        inst_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(inst_valid_o), 32'd0);
        check("rst_inst", inst_o, NOP);
        check("rst_iaddr", inst_addr_o, 32'd0);
        check("rst_rom_en", 32'(rom_en_o), 32'd0);
        check("rst_pc", rom_addr_o, 32'd0);

        // Release reset, stream 0,4 then stall on 8 for three cycles.
        @(posedge clk); #1;
        rst = 1'b0;
        sb.push_back(32'h0); sb.push_back(32'h4);
        sb.push_back(32'h8); sb.push_back(32'hC);
        @(negedge clk);
        check("rel_rom_en", 32'(rom_en_o), 32'd1);
        check("rel_valid", 32'(inst_valid_o), 32'd0);
        for (int unsigned i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stream_valid", 32'(inst_valid_o), 32'd1);
        end
        @(posedge clk); #1;
        inst_ready_i = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(inst_valid_o), 32'd1);
            check("stall_addr", inst_addr_o, 32'h8);
            check("stall_inst", inst_o, rom_word(32'h8));
            check("stall_rom_en", 32'(rom_en_o), 32'd0);
            @(posedge clk); #1;
        end
        inst_ready_i = 1'b1;
        @(negedge clk);
        check("drain_addr", inst_addr_o, 32'h8);
        check("drain_rom_en", 32'(rom_en_o), 32'd0);
        @(negedge clk);
        check("drain_bubble", 32'(inst_valid_o), 32'd0);
        check("drain_issue", 32'(rom_en_o), 32'd1);
        @(negedge clk);
        check("after_stall", inst_addr_o, 32'hC);

        // Stall on 0x10, let it land in the skid, then redirect to 0x40.
        @(posedge clk); #1;
        inst_ready_i = 1'b0;
        @(negedge clk);
        check("skid_pre", inst_addr_o, 32'h10);
        @(posedge clk); #1;
        check("skid_full", inst_addr_o, 32'h10);
        jump_to(32'h40, 3);

        // Misaligned target.
        @(posedge clk); #1;
        jump_to(32'h0000_0046, 3);

        // PC wrap.
        @(posedge clk); #1;
        jump_to(32'hFFFF_FFF8, 4);

        // Reset while stalled with a full skid.
        @(posedge clk); #1;
        jump_to(32'h80, 2);
        @(posedge clk); #1;
        inst_ready_i = 1'b0;
        @(negedge clk);
        check("rs_stall_addr", inst_addr_o, 32'h88);
        @(posedge clk); #1;
        check("rs_skid_addr", inst_addr_o, 32'h88);
        #2 rst = 1'b1;
        #1;
        check("rs_valid", 32'(inst_valid_o), 32'd0);
        check("rs_inst", inst_o, NOP);
        check("rs_rom_en", 32'(rom_en_o), 32'd0);
        check("rs_pc", rom_addr_o, 32'd0);
        @(posedge clk); #1;
        rst          = 1'b0;
        inst_ready_i = 1'b1;
        sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
        @(negedge clk);
        check("rs_rel_issue", 32'(rom_en_o), 32'd1);
        check("rs_rel_pc", rom_addr_o, 32'd0);
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rs_stream", 32'(inst_valid_o), 32'd1);
        end
        @(posedge clk); #1;
        inst_ready_i = 1'b0;
        @(negedge clk);
        check("sb_left", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/neorv32_if.md
NEORV32_IF -- requirements
Module: neorv32_if

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, is the value driven on inst_o whenever inst_valid_o is 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 jump_en_i  input  1  redirect request from execute (branch/jump taken).
REQ-006 jump_addr_i  input  32  redirect target.
REQ-007 rom_en_o  output  1  instruction ROM read strobe; a read is issued in every cycle it is 1.
REQ-008 rom_addr_o  output  32  ROM byte address, always equal to the PC register.
REQ-009 rom_data_i  input  32  ROM read data, valid exactly one cycle after a cycle with rom_en_o=1.
REQ-010 inst_valid_o  output  1  instruction available to the decode stage.
REQ-011 inst_ready_i  input  1  decode stage accepts the instruction this cycle.
REQ-012 inst_o  output  32  instruction word.
REQ-013 inst_addr_o  output  32  byte address of inst_o.

Function
REQ-014 State: pc (32), req_vld and req_addr (in-flight read), skid_vld, skid_inst and skid_addr (one-entry skid buffer).
REQ-015 Output stall: stall = inst_valid_o & ~inst_ready_i.
REQ-016 Issue: rom_en_o = ~jump_en_i & ~skid_vld & ~stall.
REQ-017 On issue: req_addr <= pc, req_vld <= 1, pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0). Otherwise: req_vld <= 0 and pc holds.
REQ-018 Output select: if skid_vld, the outputs are skid_inst/skid_addr with valid=1; else if req_vld, they are rom_data_i/req_addr with valid=1; else valid=0.
REQ-019 inst_valid_o SHALL be forced to 0 in any cycle with jump_en_i=1.
REQ-020 Skid capture: if req_vld & ~skid_vld & stall, then skid_inst <= rom_data_i, skid_addr <= req_addr and skid_vld <= 1.
REQ-021 Skid drain: if skid_vld & inst_ready_i & ~jump_en_i, then skid_vld <= 0; the next issue follows one cycle later, giving one bubble.
REQ-022 The skid buffer never overflows: issue is blocked while the skid is full or the output is stalled, so no read is ever in flight when a capture occurs.
REQ-023 Redirect: jump_en_i=1 sets pc <= {jump_addr_i[31:2],2'b00} and clears req_vld and skid_vld. The in-flight or buffered instruction is discarded, no read is issued that cycle, and fetch resumes at the target on the next cycle.
REQ-024 A redirect overrides a simultaneous stall, capture, drain or issue.
REQ-025 Throughput: with inst_ready_i held at 1 and no redirect, one instruction per cycle at consecutive addresses.
REQ-026 Redirect latency: the target instruction appears on inst_o two cycles after the jump_en_i cycle.
REQ-027 inst_o/inst_addr_o SHALL hold stable while inst_valid_o=1 and inst_ready_i=0.

Reset
REQ-028 While rst=1: pc=RESET_PC, req_vld=0, skid_vld=0, inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=0, rom_en_o=0.
REQ-029 Assertion of rst mid-operation discards all in-flight and buffered instructions immediately (asynchronous).
REQ-030 The first read, at RESET_PC, is issued in the first clock edge after rst deasserts; the first valid instruction appears the cycle after that.

Verification
REQ-031 Reset release with ROM word i = 32'h1000_0000+i and ready=1: one valid instruction per cycle.
- Required: addresses 0,4,8,... and data 32'h1000_0000, 32'h1000_0001, ... in order with no gaps.
REQ-032 ready=0 for 3 cycles while the instruction at 0x8 is presented:
- Required: 0x8 is held stable, rom_en_o=0 during the stall, the instruction at 0xC follows after one bubble, and nothing is lost or duplicated.
REQ-033 jump_en_i=1 with target 0x40 while the instruction at 0x10 is valid and the skid is full:
- Required: inst_valid_o=0 that cycle and the instruction at 0x40 is valid two cycles later.
- Required: the buffered and in-flight instructions (0x10 and later) never appear after the jump.
REQ-034 jump_addr_i=0x0000_0046: fetch resumes at 0x44.
REQ-035 PC at 0xFFFF_FFF8 with ready=1: addresses 0xFFFF_FFF8, 0xFFFF_FFFC and 0x0000_0000 appear consecutively.
REQ-036 rst asserted while stalled with the skid full:
- Required: inst_valid_o=0 immediately, inst_o=NOP_INST.
- Required: after release, fetch restarts at RESET_PC.
